// File: rtl/bcd_time_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared constants and the time-validation helper for the
//                BCD time-of-day counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam int                  NIBBLE_W     = 4;
    localparam logic [NIBBLE_W-1:0] MAX_DIGIT    = 4'd9;
    localparam logic [NIBBLE_W-1:0] MAX_MIN_TENS = 4'd5;

    localparam logic [7:0] MAX_HR_24    = 8'h23;
    localparam logic [7:0] MAX_HR_12    = 8'h12;
    localparam logic [7:0] MIN_HR_12    = 8'h01;
    // 12h mode: leaving this hour flips AM/PM
    localparam logic [7:0] HR_PM_TOGGLE = 8'h11;

    // Reset values, laid out H1 H0 M1 M0 S1 S0
    localparam logic [23:0] RST_TIME_24 = 24'h000000;
    localparam logic [23:0] RST_TIME_12 = 24'h120000;

    // Returns 1 when t (H1 H0 M1 M0 S1 S0) is a legal time for the mode.
    // Once every nibble is known to be decimal, a plain binary compare of
    // the hour byte orders the same way as the BCD value.
    function automatic logic time_is_valid(input logic [23:0] t, input logic mode24);
        logic       ok;
        logic [7:0] hr;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[NIBBLE_W*i +: NIBBLE_W] > MAX_DIGIT) ok = 1'b0;
        end
        if (t[7:4] > MAX_MIN_TENS)   ok = 1'b0;
        if (t[15:12] > MAX_MIN_TENS) ok = 1'b0;
        hr = t[23:16];
        if (mode24) begin
            if (hr > MAX_HR_24) ok = 1'b0;
        end else begin
            if ((hr < MIN_HR_12) || (hr > MAX_HR_12)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_time_counter_if
//  Description : Control / load / display bundle of the time counter.
//                master = stimulus side, slave = counter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_time_counter_if #(
    parameter int TW = 16
);
    logic          tick;
    logic          hold;
    logic          load;
    logic [TW-1:0] load_time;
    logic          load_pm;
    logic [TW-1:0] disp_time;
    logic          pm;
    logic          min_wrap;
    logic          day_wrap;
    logic          load_err;

    modport master (
        output tick, hold, load, load_time, load_pm,
        input  disp_time, pm, min_wrap, day_wrap, load_err
    );

    modport slave (
        input  tick, hold, load, load_time, load_pm,
        output disp_time, pm, min_wrap, day_wrap, load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_time_counter_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit with parallel load, clear and wrapping
//                increment; carry flags the wrap of this digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import alarm_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] MAX     = 4'd9,
    parameter logic [NIBBLE_W-1:0] RST_VAL = 4'd0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    input  logic                clr,
    input  logic                ld,
    input  logic [NIBBLE_W-1:0] ld_val,
    output logic [NIBBLE_W-1:0] q,
    output logic                carry
);

    logic [NIBBLE_W-1:0] r_q;

    // Digit register: load beats clear beats increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_q <= RST_VAL;
        else if (ld)       r_q <= ld_val;
        else if (clr)      r_q <= '0;
        else if (inc)      r_q <= (r_q == MAX) ? '0 : r_q + 4'd1;
    end

    assign q     = r_q;
    assign carry = inc & (r_q == MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_time_counter
//  Description : BCD time-of-day counter, 24h or 12h AM/PM, optional
//                seconds, validated synchronous load, wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
    parameter bit MODE_24      = 1'b1,
    parameter bit WITH_SECONDS = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    bcd_time_counter_if.slave bus
);
    import alarm_pkg::*;

    localparam int          TW         = 16 + 8 * int'(WITH_SECONDS);
    localparam logic [23:0] c_rst_time = MODE_24 ? RST_TIME_24 : RST_TIME_12;

    logic [23:0]   w_load_full;
    logic          w_load_ok;
    logic          w_adv;
    logic          w_min_tick;
    logic [3:0]    w_m0, w_m1, w_h0;
    logic          w_m0_carry, w_m1_carry, w_h0_carry;
    logic [3:0]    r_h1;
    logic [7:0]    w_hr;
    logic          w_hr_inc, w_hr_wrap, w_noon, w_day_wrap;
    logic          w_h0_ld;
    logic [3:0]    w_h0_ld_val;
    logic          r_pm, r_min_wrap, r_day_wrap, r_load_err;
    logic [TW-1:0] w_disp;

    // A load always wins the cycle, so a coincident tick is simply dropped
    assign w_load_ok = bus.load & time_is_valid(w_load_full, MODE_24);
    assign w_adv     = bus.tick & ~bus.hold & ~bus.load;

    generate
        if (WITH_SECONDS) begin : g_sec
            logic [3:0] w_s0, w_s1;
            logic       w_s0_carry, w_s1_carry;

            assign w_load_full = 24'(bus.load_time);

            bcd_digit #(.MAX(MAX_DIGIT), .RST_VAL(c_rst_time[3:0])) u_s0 (
                .clk(clk), .reset_n(reset_n), .inc(w_adv), .clr(1'b0),
                .ld(w_load_ok), .ld_val(w_load_full[3:0]),
                .q(w_s0), .carry(w_s0_carry)
            );
            bcd_digit #(.MAX(MAX_MIN_TENS), .RST_VAL(c_rst_time[7:4])) u_s1 (
                .clk(clk), .reset_n(reset_n), .inc(w_s0_carry), .clr(1'b0),
                .ld(w_load_ok), .ld_val(w_load_full[7:4]),
                .q(w_s1), .carry(w_s1_carry)
            );

            assign w_min_tick = w_s1_carry;
            assign w_disp     = {r_h1, w_h0, w_m1, w_m0, w_s1, w_s0};
        end else begin : g_no_sec
            // Seconds are absent: pad them as 00 so one validator serves both
            assign w_load_full = {bus.load_time[15:0], 8'h00};
            assign w_min_tick  = w_adv;
            assign w_disp      = {r_h1, w_h0, w_m1, w_m0};
        end
    endgenerate

    bcd_digit #(.MAX(MAX_DIGIT), .RST_VAL(c_rst_time[11:8])) u_m0 (
        .clk(clk), .reset_n(reset_n), .inc(w_min_tick), .clr(1'b0),
        .ld(w_load_ok), .ld_val(w_load_full[11:8]),
        .q(w_m0), .carry(w_m0_carry)
    );
    bcd_digit #(.MAX(MAX_MIN_TENS), .RST_VAL(c_rst_time[15:12])) u_m1 (
        .clk(clk), .reset_n(reset_n), .inc(w_m0_carry), .clr(1'b0),
        .ld(w_load_ok), .ld_val(w_load_full[15:12]),
        .q(w_m1), .carry(w_m1_carry)
    );

    // Hour wrap is irregular (23->00 or 12->01), so it is forced through
    // the H0 load path instead of the digit's own increment.
    assign w_hr        = {r_h1, w_h0};
    assign w_hr_inc    = w_m1_carry;
    assign w_hr_wrap   = w_hr_inc & (w_hr == (MODE_24 ? MAX_HR_24 : MAX_HR_12));
    assign w_noon      = ~MODE_24 & w_hr_inc & (w_hr == HR_PM_TOGGLE);
    assign w_day_wrap  = MODE_24 ? w_hr_wrap : (w_noon & r_pm);
    assign w_h0_ld     = w_load_ok | w_hr_wrap;
    assign w_h0_ld_val = w_load_ok ? w_load_full[19:16] : (MODE_24 ? 4'd0 : 4'd1);

    bcd_digit #(.MAX(MAX_DIGIT), .RST_VAL(c_rst_time[19:16])) u_h0 (
        .clk(clk), .reset_n(reset_n), .inc(w_hr_inc & ~w_hr_wrap), .clr(1'b0),
        .ld(w_h0_ld), .ld_val(w_h0_ld_val),
        .q(w_h0), .carry(w_h0_carry)
    );

    // Hours tens digit: load, wrap to zero, or take the H0 carry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_h1 <= c_rst_time[23:20];
        else if (w_load_ok)  r_h1 <= w_load_full[23:20];
        else if (w_hr_wrap)  r_h1 <= 4'd0;
        else if (w_h0_carry) r_h1 <= r_h1 + 4'd1;
    end

    // AM/PM flag and the single-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pm       <= 1'b0;
            r_min_wrap <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_load_ok)   r_pm <= bus.load_pm & ~MODE_24;
            else if (w_noon) r_pm <= ~r_pm;
            r_min_wrap <= w_m1_carry;
            r_day_wrap <= w_day_wrap;
            r_load_err <= bus.load & ~w_load_ok;
        end
    end

    assign bus.disp_time = w_disp;
    assign bus.pm        = r_pm;
    assign bus.min_wrap  = r_min_wrap;
    assign bus.day_wrap  = r_day_wrap;
    assign bus.load_err  = r_load_err;

endmodule
`default_nettype wire

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Parametrised BCD time-of-day counter for the alarm clock datapath.
- Advances on a one-cycle `tick` strobe from the prescaler; supports synchronous time load with validation.
- Hour format is 24h or 12h AM/PM; the seconds field is optional.
- Output drives the display mux and the alarm comparator directly, so it is always a legal BCD time.

Parameters:
- MODE_24, 1, 1 = 24-hour format (00-23); 0 = 12-hour format (01-12 plus `pm` flag).
- WITH_SECONDS, 0, 1 = HH:MM:SS (24-bit time); 0 = HH:MM (16-bit time); `tick` is then one second or one minute respectively.
- TW, 16+8*WITH_SECONDS, derived time width; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- tick  input  1  count strobe, one clk cycle wide, one LS unit per strobe.
- hold  input  1  freezes counting; load still honoured.
- load  input  1  set_time strobe; captures load_time/load_pm.
- load_time  input  TW  BCD time, nibbles MS to LS: H1 H0 M1 M0 [S1 S0].
- load_pm  input  1  PM flag for a load; ignored when MODE_24=1.
- disp_time  output  TW  current BCD time, registered.
- pm  output  1  1 = PM; constant 0 when MODE_24=1.
- min_wrap  output  1  one-cycle pulse when minutes go 59 -> 00.
- day_wrap  output  1  one-cycle pulse on the midnight transition.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - disp_time = 00:00[:00] if MODE_24, else 12:00[:00].
  - pm=0, min_wrap=0, day_wrap=0, load_err=0.
- All updates occur on the rising clk edge and are visible in the next cycle; no combinational path from inputs to outputs.
- Priority per cycle: load > (tick & !hold) > idle. A tick coincident with load is discarded.
- Load validation: every nibble ≤ 9, M1 ≤ 5, S1 ≤ 5.
  - Hours must be 00-23 if MODE_24, 01-12 otherwise.
  - Valid load: disp_time <= load_time; pm <= load_pm & !MODE_24.
  - Invalid load: time and pm unchanged; load_err=1 for one cycle.
- Counting on an accepted tick:
  - Digits form a BCD ripple. The LS digit increments; each digit wraps to 0 past 9, or past 5 for S1/M1, and carries into the next digit.
  - Hours advance only on the minute carry.
- 24h mode: 23:59[:59] -> 00:00[:00]; day_wrap=1 on that edge.
- 12h mode:
  - 11:59 -> 12:00 toggles pm.
  - 12:59 -> 01:00 leaves pm unchanged.
  - day_wrap=1 only on the PM->AM toggle (11:59 PM -> 12:00 AM).
- min_wrap pulses on every minutes 59->00 transition, including the one coincident with day_wrap. It is never raised by a load.
- Pulses (min_wrap, day_wrap, load_err) deassert the next cycle unless re-triggered.
- Reset asserted mid-count: immediate return to reset values. Outputs stay static until the first accepted tick or load after reset_n rises.
- hold=1 with tick: time is unchanged and no wrap pulses are generated; the tick is lost, not queued.
- Back-to-back ticks on consecutive cycles are legal, and each advances one unit.

Decomposition:
- Package alarm_pkg:
  - BCD nibble width (4).
  - Limit constants MAX_MIN_TENS=5, MAX_HR_24=8'h23, MAX_HR_12=8'h12, MIN_HR_12=8'h01.
  - Reset-value constants for both modes.
  - A function returning 1 for a valid BCD time, given the mode.
- Sub-module bcd_digit:
  - Parameter MAX (wrap value).
  - Inputs inc, clr, ld, ld_val.
  - Outputs q[3:0] and carry (inc & q==MAX).
  - Instantiate for S0, S1, M0, M1, H0. Hours tens and the 12/24 hour wrap stay in the top level.

Test Plan:
- Full day: MODE_24=1, WITH_SECONDS=0, 1441 ticks from reset -> disp_time 16'h0001; day_wrap pulsed once (tick 1440); min_wrap pulsed 24 times.
- Load and count: load_time=16'h1145, then 121 ticks -> disp_time 16'h1346. Then pulse reset_n low -> 16'h0000. Then 121 ticks -> 16'h0201.
- 12h mode: load 11:59 with load_pm=1, 1 tick -> 12:00, pm=0, day_wrap=1. Load 12:59 AM, 1 tick -> 01:00, pm=0, day_wrap=0.
- Invalid load: load_time=16'h2460 (MODE_24) -> load_err=1 one cycle, disp_time unchanged. load_time=16'h0000 with MODE_24=0 -> rejected.
- Seconds: WITH_SECONDS=1, load 24'h235959, 1 tick -> 24'h000000, min_wrap=1 and day_wrap=1 in the same cycle.
- Priority: load and tick in the same cycle -> loaded value exactly, no increment. hold=1 with 10 ticks -> no change.
